// File: rtl/io_uart_tx_if.sv
// io_bus_interface: simple memory-mapped IO bus (one-cycle registered read data)
//   write_en/read_en : access strobes
//   address          : byte address
//   write_data       : store data
//   read_data        : load data, driven by the slave
interface io_bus_interface;
    logic        write_en;
    logic        read_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    modport slave (input write_en, read_en, address, write_data, output read_data);
    modport master (output write_en, read_en, address, write_data, input read_data);
endinterface

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a circular transmit FIFO
//   clk     : clock, all state on rising edge
//   reset   : synchronous active-high reset
//   io_bus  : register port (+0 STATUS, +4 TX_DATA, +8 DIVISOR), read data one cycle later
//   uart_tx : serial line, idle high
module io_uart_tx #(
    parameter logic [31:0] BASE_ADDRESS    = 32'hFFFF0040,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd27
) (
    input  logic            clk,
    input  logic            reset,
    io_bus_interface.slave  io_bus,
    output logic            uart_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q;
    logic [15:0]   div_q, bdiv_q, bdiv_d, clk_cnt_q, clk_cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic [31:0]   rd_q;
    logic          sel_st, sel_tx, sel_dv, push, pop, empty, full, busy, bit_end;
    logic          unused_wd;

    assign sel_st    = io_bus.address == BASE_ADDRESS;
    assign sel_tx    = io_bus.address == BASE_ADDRESS + 32'h4;
    assign sel_dv    = io_bus.address == BASE_ADDRESS + 32'h8;
    assign empty     = count_q == '0;
    assign full      = count_q == (AW+1)'(FIFO_DEPTH);
    assign busy      = !empty || state_q != IDLE;
    // a pop in the same cycle frees the slot a full FIFO would otherwise refuse
    assign push      = io_bus.write_en && sel_tx && (!full || pop);
    assign bit_end   = clk_cnt_q == bdiv_q - 16'd1;
    assign unused_wd = ^io_bus.write_data[31:16];

    always_comb begin
        state_d   = state_q;
        bdiv_d    = bdiv_q;
        clk_cnt_d = clk_cnt_q + 16'd1;
        bit_d     = bit_q;
        sh_d      = sh_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                pop       = !empty;
            end
            START: if (bit_end) begin
                state_d   = DATA;
                clk_cnt_d = '0;
                tx_d      = sh_q[0];
            end
            DATA: if (bit_end) begin
                clk_cnt_d = '0;
                sh_d      = sh_q >> 1;
                bit_d     = bit_q + 3'd1;
                state_d   = bit_q == 3'd7 ? STOP : DATA;
                tx_d      = bit_q == 3'd7 ? 1'b1 : sh_q[1];
            end
            STOP: if (bit_end) begin
                clk_cnt_d = '0;
                state_d   = IDLE;
                tx_d      = 1'b1;
                pop       = !empty;
            end
            default: state_d = IDLE;
        endcase
        // loading a byte (from IDLE or straight out of STOP) starts a frame; the divisor is frozen here
        if (pop) begin
            state_d   = START;
            sh_d      = mem_q[rptr_q];
            bdiv_d    = div_q;
            clk_cnt_d = '0;
            bit_d     = '0;
            tx_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= io_bus.write_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            div_q     <= DEFAULT_DIVISOR;
            bdiv_q    <= DEFAULT_DIVISOR;
            clk_cnt_q <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            tx_q      <= 1'b1;
            rd_q      <= '0;
        end else begin
            state_q   <= state_d;
            bdiv_q    <= bdiv_d;
            clk_cnt_q <= clk_cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            tx_q      <= tx_d;
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop) rptr_q <= rptr_q + AW'(1);
            count_q   <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            // a drop in the same cycle as a STATUS read stays visible for the next read
            ovf_q     <= (io_bus.write_en && sel_tx && !push) || (ovf_q && !(io_bus.read_en && sel_st));
            if (io_bus.write_en && sel_dv)
                div_q <= io_bus.write_data[15:0] < 16'd2 ? 16'd2 : io_bus.write_data[15:0];
            rd_q      <= !io_bus.read_en ? 32'd0 :
                         sel_st ? {28'd0, ovf_q, empty, busy, !full} :
                         sel_dv ? {16'd0, div_q} : 32'd0;
        end
    end

    assign io_bus.read_data = rd_q;
    assign uart_tx          = tx_q;
endmodule

// File: tb/tb_io_uart_tx.sv
// tb_io_uart_tx: randomized directed bench for io_uart_tx with a transaction-level reference model
module tb_io_uart_tx;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] BASE   = 32'hFFFF0040;
    localparam logic [15:0] DEFDIV = 16'd27;

    typedef struct {
        logic [7:0] b;
        int         d;
    } frame_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_tx;
    int checks = 0;
    int errors = 0;

    io_bus_interface bus();

    io_uart_tx #(.BASE_ADDRESS(BASE), .FIFO_DEPTH(DEPTH), .DEFAULT_DIVISOR(DEFDIV)) dut (
        .clk(clk),
        .reset(reset),
        .io_bus(bus),
        .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    // Reference model: a byte queue plus "clocks left in the current frame".
    logic [7:0]  mq[$];
    frame_t      fq[$];
    int          rem = 0;
    logic        ovf = 1'b0;
    logic [15:0] mdiv = DEFDIV;
    logic [31:0] exp_rd = 32'd0;
    longint      cyc = 0;

    initial forever begin
        logic rd_st, rd_dv, wr_tx, wr_dv, pop;
        @(posedge clk);
        cyc++;
        if (reset) begin
            mq.delete();
            fq.delete();
            rem = 0;
            ovf = 1'b0;
            mdiv = DEFDIV;
            exp_rd = 32'd0;
        end else begin
            rd_st = bus.read_en && bus.address == BASE;
            rd_dv = bus.read_en && bus.address == BASE + 32'h8;
            wr_tx = bus.write_en && bus.address == BASE + 32'h4;
            wr_dv = bus.write_en && bus.address == BASE + 32'h8;
            exp_rd = rd_st ? {28'd0, ovf, mq.size() == 0, mq.size() != 0 || rem != 0, mq.size() < DEPTH} :
                     rd_dv ? {16'd0, mdiv} : 32'd0;
            pop = rem <= 1 && mq.size() != 0;
            if (rd_st) ovf = 1'b0;
            if (wr_tx && !(mq.size() < DEPTH || pop)) ovf = 1'b1;
            if (pop) begin
                fq.push_back('{mq.pop_front(), int'(mdiv)});
                rem = 10 * int'(mdiv);
            end else if (rem > 0) begin
                rem--;
            end
            if (wr_tx && mq.size() < DEPTH) mq.push_back(bus.write_data[7:0]);
            if (wr_dv) mdiv = bus.write_data[15:0] < 16'd2 ? 16'd2 : bus.write_data[15:0];
        end
    end

    // read_data must equal the model's expectation in every cycle, reads or not
    initial forever begin
        @(posedge clk);
        #1;
        checks++;
        assert (bus.read_data === exp_rd) else begin
            errors++;
            $error("FAIL read_data got %h expected %h at cycle %0d", bus.read_data, exp_rd, cyc);
        end
    end

    // Line monitor: every start bit must match the next modelled frame, sample by sample.
    longint starts[$];
    int     frames = 0;
    bit     mon_busy = 1'b0;

    initial forever begin
        frame_t f;
        int     k;
        logic   e;
        @(posedge clk);
        #1;
        if (!reset && uart_tx === 1'b0) begin
            mon_busy = 1'b1;
            starts.push_back(cyc);
            checks++;
            assert (fq.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_frame got start bit expected idle at cycle %0d", cyc);
            end
            if (fq.size() != 0) begin
                f = fq.pop_front();
                for (int i = 0; i < 10 * f.d; i++) begin
                    if (i != 0) begin
                        @(posedge clk);
                        #1;
                    end
                    if (reset) break;
                    k = i / f.d;
                    e = k == 0 ? 1'b0 : k == 9 ? 1'b1 : f.b[k-1];
                    checks++;
                    assert (uart_tx === e) else begin
                        errors++;
                        $error("FAIL line byte %h sample %0d got %b expected %b", f.b, i, uart_tx, e);
                    end
                end
                if (!reset) frames++;
            end
            mon_busy = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        @(negedge clk);
        bus.write_en = 1'b1;
        bus.address = BASE + off;
        bus.write_data = d;
        @(posedge clk);
        #1;
        bus.write_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] d);
        @(negedge clk);
        bus.read_en = 1'b1;
        bus.address = BASE + off;
        @(posedge clk);
        #1;
        d = bus.read_data;
        bus.read_en = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        logic done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (mq.size() == 0 && rem == 0 && !mon_busy) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("idle_timeout", {31'd0, done}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [31:0] r;
    int          f0, s0;
    logic        stayed_high;
    logic        started;

    initial begin
        bus.write_en = 1'b0;
        bus.read_en = 1'b0;
        bus.address = 32'd0;
        bus.write_data = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        chk("reset_tx", {31'd0, uart_tx}, 32'd1);
        rd(32'h0, r);
        chk("reset_status", r, 32'h5);
        rd(32'h8, r);
        chk("reset_divisor", r, 32'd27);
        rd(32'h4, r);
        chk("txdata_read_zero", r, 32'd0);
        rd(32'h40, r);
        chk("undecoded_read_zero", r, 32'd0);
        wr(32'h0, 32'hFFFF_FFFF);
        wr(32'hC, 32'hFFFF_FFFF);
        rd(32'h0, r);
        chk("status_write_ignored", r, 32'h5);

        // single A5 frame at divisor 4
        f0 = frames;
        wr(32'h8, 32'd4);
        wr(32'h4, 32'hA5);
        repeat (5) @(posedge clk);
        rd(32'h0, r);
        chk("busy_during_frame", r & 32'h2, 32'h2);
        wait_idle(200);
        rd(32'h0, r);
        chk("status_after_frame", r, 32'h5);
        chk("a5_frames", frames - f0, 32'd1);

        // back-to-back frames: no idle gap between stop and next start
        s0 = starts.size();
        f0 = frames;
        wr(32'h4, 32'h01);
        wr(32'h4, 32'hFF);
        wait_idle(300);
        chk("b2b_frames", frames - f0, 32'd2);
        chk("b2b_spacing", 32'(starts[s0+1] - starts[s0]), 32'd40);

        // random bytes at random divisors
        for (int n = 0; n < 4; n++) begin
            f0 = frames;
            wr(32'h8, $urandom_range(2, 6));
            for (int j = 0; j < 3; j++) wr(32'h4, $urandom_range(0, 255));
            wait_idle(1000);
            chk("rand_frames", frames - f0, 32'd3);
        end

        // overflow: DEPTH+2 consecutive writes at divisor 100, one byte dropped
        f0 = frames;
        wr(32'h8, 32'd100);
        for (int j = 0; j < DEPTH + 2; j++) wr(32'h4, $urandom_range(0, 255));
        rd(32'h0, r);
        chk("ovf_status_first", r, 32'hA);
        rd(32'h0, r);
        chk("ovf_status_second", r, 32'h2);
        wait_idle(12000);
        chk("ovf_frames", frames - f0, DEPTH + 1);

        // divisor clamping and mid-frame divisor change
        wr(32'h8, 32'd0);
        rd(32'h8, r);
        chk("div0_clamped", r, 32'd2);
        wr(32'h8, 32'd1);
        rd(32'h8, r);
        chk("div1_clamped", r, 32'd2);
        s0 = starts.size();
        f0 = frames;
        wr(32'h8, 32'd4);
        wr(32'h4, $urandom_range(0, 255));
        wr(32'h4, $urandom_range(0, 255));
        repeat (10) @(posedge clk);
        wr(32'h8, 32'd8);
        wait_idle(500);
        chk("middiv_frames", frames - f0, 32'd2);
        chk("middiv_first_len", 32'(starts[s0+1] - starts[s0]), 32'd40);
        rd(32'h8, r);
        chk("middiv_readback", r, 32'd8);

        // reset during DATA bit 3 aborts the frame and drops pending bytes
        wr(32'h8, 32'd4);
        wr(32'h4, $urandom_range(0, 255));
        wr(32'h4, $urandom_range(0, 255));
        started = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mon_busy) begin
                started = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("reset_frame_started", {31'd0, started}, 32'd1);
        repeat (16) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_abort_tx", {31'd0, uart_tx}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        rd(32'h0, r);
        chk("reset_abort_status", r, 32'h5);
        s0 = starts.size();
        stayed_high = 1'b1;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (uart_tx !== 1'b1) stayed_high = 1'b0;
        end
        chk("reset_no_frames", {31'd0, stayed_high}, 32'd1);
        chk("reset_no_starts", starts.size() - s0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
